// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the N-way arbitrating output mux.
package arb_mux_pkg;

   // Largest channel count the arbiter is meant to be built with.
   localparam int ARB_MAX_N = 16;

   // Width of a channel index; never narrower than one bit.
   function automatic int sel_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// rr_pick: combinational winner search. The search begins at i_ptr and
// ascends, wrapping N-1 -> 0. The first requesting channel wins. The result
// is a one-hot grant, the winner index, and an any-request flag.
module rr_pick
   import arb_mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = sel_w(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [SW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [SW-1:0] o_winner,
   output logic          o_any
);

   // Scan N positions starting from the pointer; the first hit is latched via o_any.
   always_comb begin
      int w_idx;
      o_grant  = '0;
      o_winner = '0;
      o_any    = 1'b0;
      w_idx    = 0;
      for (int k = 0; k < N; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= N) w_idx = w_idx - N;
         if (!o_any && i_req[SW'(w_idx)]) begin
            o_grant[SW'(w_idx)] = 1'b1;
            o_winner            = SW'(w_idx);
            o_any               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbiter feeding a single registered output slot.
// Round-robin by default. Defining ARB_MUX_FIXED_PRIO_EN selects fixed
// priority (the lowest index wins) and pins the pointer at 0.
// The output slot loads whenever it is empty or being drained, which
// sustains one word per cycle.
module arb_mux_n
   import arb_mux_pkg::*;
#(
   parameter  int WIDTH = 64,
   parameter  int N     = 4,
   localparam int SW    = sel_w(N)
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [N-1:0]              in_valid,
   input  logic [N-1:0][WIDTH-1:0]   in_data,
   output logic [N-1:0]              in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SW-1:0]             out_sel,
   input  logic                      out_ready
);

   logic [SW-1:0]    r_ptr;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SW-1:0]    r_out_sel;

   logic             w_load;
   logic [N-1:0]     w_req;
   logic [N-1:0]     w_grant;
   logic [SW-1:0]    w_winner;
   logic             w_any;
   logic [SW-1:0]    w_ptr_nxt;

   // The slot can take a word when it is empty or its word leaves this cycle.
   // Requests are masked in reset, so no channel sees ready then.
   always_comb begin
      w_load = ~r_out_valid | out_ready;
      w_req  = (reset_n && w_load) ? in_valid : '0;
   end

   rr_pick #(.N(N)) u_pick (
      .i_req    (w_req),
      .i_ptr    (r_ptr),
      .o_grant  (w_grant),
      .o_winner (w_winner),
      .o_any    (w_any)
   );

   // Pointer successor. Fixed priority keeps the search anchored at channel 0.
   always_comb begin
`ifdef ARB_MUX_FIXED_PRIO_EN
      w_ptr_nxt = '0;
`else
      w_ptr_nxt = (w_winner == SW'(N - 1)) ? '0 : w_winner + SW'(1);
`endif
   end

   // Output slot and pointer. A pick overwrites the slot; a drain with no pick empties it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_any) begin
         r_ptr       <= w_ptr_nxt;
         r_out_valid <= 1'b1;
         r_out_data  <= in_data[w_winner];
         r_out_sel   <= w_winner;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_grant;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n (N=4, WIDTH=64). A cycle model predicts
// grants and the pointer. Each predicted pick is queued and then compared
// when the output word is accepted downstream.
module tb_arb_mux_n;

   localparam int N = 4;
   localparam int W = 64;

   typedef struct packed {
      logic [1:0]   sel;
      logic [W-1:0] data;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [N-1:0]       in_valid;
   logic [N-1:0][W-1:0] in_data;
   logic [N-1:0]       in_ready;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic [1:0]         out_sel;
   logic               out_ready;

   exp_t       sb[$];
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [1:0] m_ptr;
   logic       m_ov;

   always #5 clk = ~clk;

   arb_mux_n #(.WIDTH(W), .N(N)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_win(input logic [N-1:0] v, input logic [1:0] p);
      int idx;
      logic [1:0] start;
      start = p;
`ifdef ARB_MUX_FIXED_PRIO_EN
      start = 2'd0;
`endif
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   // One cycle: drive, check combinational/registered state against the model, advance.
   task automatic step(input logic [N-1:0] v, input logic r, input bit rnd);
      int         win;
      bit         pick;
      logic [N-1:0] exp_rdy;
      exp_t       e;
      in_valid  = v;
      out_ready = r;
      for (int i = 0; i < N; i++)
         in_data[i] = rnd ? {$urandom, $urandom} : 64'hA0 + 64'(i);
      #1;
      win     = model_win(v, m_ptr);
      pick    = (!m_ov || r) && (win >= 0);
      exp_rdy = '0;
      if (pick) exp_rdy[win] = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("ptr", 64'(dut.r_ptr), 64'(m_ptr));
      if (m_ov && r) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("out_sel", 64'(out_sel), 64'(e.sel));
            chk("out_data", out_data, e.data);
         end
      end
      if (pick) begin
         e.sel  = 2'(win);
         e.data = in_data[win];
         sb.push_back(e);
`ifdef ARB_MUX_FIXED_PRIO_EN
         m_ptr = 2'd0;
`else
         m_ptr = 2'((win + 1) % N);
`endif
         m_ov = 1'b1;
      end else if (r) begin
         m_ov = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      in_data   = '0;
      m_ptr     = 2'd0;
      m_ov      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_sel", 64'(out_sel), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b1;

      // All channels requesting, downstream always ready: expect sel 0,1,2,3,0.
      repeat (5) step(4'b1111, 1'b1, 1'b0);
      // Lone request on channel 2 moves the pointer to 3.
      step(4'b0100, 1'b1, 1'b0);
      // Stall: the slot must hold while data on the inputs keeps changing.
      repeat (5) step(4'b1111, 1'b0, 1'b1);
      step(4'b1111, 1'b1, 1'b1);
      // Wrap case: ptr=3 with only channels 0/1 requesting.
      step(4'b0100, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      step(4'b0011, 1'b1, 1'b1);
      // Build up a stalled word, then reset in the middle of the cycle.
      step(4'b1000, 1'b0, 1'b1);
      step(4'b0000, 1'b0, 1'b1);
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_out_sel", 64'(out_sel), 64'd0);
      chk("arst_out_data", out_data, 64'd0);
      chk("arst_ptr", 64'(dut.r_ptr), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b1;
      sb.delete();
      m_ptr = 2'd0;
      m_ov  = 1'b0;

      // Mixed traffic with random requests and backpressure.
      repeat (40) step(4'($urandom), 1'($urandom_range(0, 3) != 0), 1'b1);
      repeat (3) step(4'b0000, 1'b1, 1'b1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
